// File: rtl/kv_pkg.sv
// Shared encodings for the key-value store bus initiator.
package kv_pkg;

  localparam int KV_DW = 7;
  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    OP_GET_IDX  = 2'd0,
    OP_GET_KEY  = 2'd1,
    OP_PUT      = 2'd2,
    OP_SET_SLOT = 2'd3
  } kv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RSP   = 2'd2,
    ST_DRAIN = 2'd3
  } kv_state_e;

endpackage

// File: rtl/kv_watchdog.sv
// Saturating no-acknowledge counter; flags the cycle in which a bus request
// has waited TIMEOUT cycles without being acknowledged.
module kv_watchdog #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_r;

  assign expire = enable & (count_r == LIMIT);

  // Count enabled cycles since the last clear, holding at the top of the range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/kv_wb_initiator.sv
// Turns local commands into single classic Wishbone cycles towards the
// key-value responder, with ACK-drop handshake and a no-ACK watchdog.
module kv_wb_initiator
  import kv_pkg::*;
#(
  parameter int DW      = KV_DW,
  parameter int TIMEOUT = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [DW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_data_i,
  input  logic          cmd_slot_is_key_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_data_o,
  output logic          rsp_err_o,
  output logic          STB_o,
  output logic          CYC_o,
  output logic          WE_o,
  output logic [DW-1:0] ADR_o,
  output logic [DW-1:0] DAT_o,
  output logic          ADR_IS_KEY_o,
  output logic          DAT_IS_KEY_o,
  output logic [3:0]    SEL_o,
  input  logic          ACK_i,
  input  logic          STALL_i,
  input  logic [DW-1:0] DAT_i,
  output logic          busy_o
);

  kv_state_e     state_r, state_s;
  logic          stb_r, stb_s;
  logic          we_r, we_s;
  logic [DW-1:0] adr_r, adr_s;
  logic [DW-1:0] dat_r, dat_s;
  logic          aik_r, aik_s;
  logic          dik_r, dik_s;
  logic          rsp_valid_r, rsp_valid_s;
  logic [DW-1:0] rsp_data_r, rsp_data_s;
  logic          rsp_err_r, rsp_err_s;
  logic          wd_clear_s, wd_enable_s, wd_expire_s;

  kv_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .clear  (wd_clear_s),
    .enable (wd_enable_s),
    .expire (wd_expire_s)
  );

  assign cmd_ready_o  = (state_r == ST_IDLE) & ~ACK_i;
  assign busy_o       = (state_r != ST_IDLE);
  assign STB_o        = stb_r;
  assign CYC_o        = stb_r;
  assign WE_o         = we_r;
  assign ADR_o        = adr_r;
  assign DAT_o        = dat_r;
  assign ADR_IS_KEY_o = aik_r;
  assign DAT_IS_KEY_o = dik_r;
  assign SEL_o        = SEL_ALL;
  assign rsp_valid_o  = rsp_valid_r;
  assign rsp_data_o   = rsp_data_r;
  assign rsp_err_o    = rsp_err_r;

  // Next-state and next-output decode for the bus cycle sequencer.
  always_comb begin
    state_s     = state_r;
    stb_s       = stb_r;
    we_s        = we_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    aik_s       = aik_r;
    dik_s       = dik_r;
    rsp_valid_s = rsp_valid_r;
    rsp_data_s  = rsp_data_r;
    rsp_err_s   = rsp_err_r;
    wd_clear_s  = 1'b0;
    wd_enable_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          state_s    = ST_REQ;
          stb_s      = 1'b1;
          adr_s      = cmd_addr_i;
          dat_s      = cmd_data_i;
          wd_clear_s = 1'b1;
          case (cmd_op_i)
            OP_GET_IDX:  begin we_s = 1'b0; aik_s = 1'b0; dik_s = 1'b0; end
            OP_GET_KEY:  begin we_s = 1'b0; aik_s = 1'b1; dik_s = 1'b0; end
            OP_PUT:      begin we_s = 1'b1; aik_s = 1'b1; dik_s = 1'b0; end
            OP_SET_SLOT: begin we_s = 1'b1; aik_s = 1'b0; dik_s = cmd_slot_is_key_i; end
            default:     begin we_s = 1'b0; aik_s = 1'b0; dik_s = 1'b0; end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        wd_enable_s = ~ACK_i;
        // An acknowledge in the expiry cycle still wins over the abort.
        if (ACK_i) begin
          state_s     = ST_RSP;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_data_s  = DAT_i;
          rsp_err_s   = 1'b0;
        end else if (wd_expire_s) begin
          state_s     = ST_RSP;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_data_s  = {DW{1'b0}};
          rsp_err_s   = 1'b1;
        end else if (STALL_i) begin
          state_s = ST_REQ;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_s = 1'b0;
          state_s     = ACK_i ? ST_DRAIN : ST_IDLE;
        end else begin
          state_s = ST_RSP;
        end
      end
      ST_DRAIN: begin
        if (!ACK_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        stb_s       = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase
  end

  // State and registered bus/response outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r     <= ST_IDLE;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= {DW{1'b0}};
      dat_r       <= {DW{1'b0}};
      aik_r       <= 1'b0;
      dik_r       <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      stb_r       <= stb_s;
      we_r        <= we_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      aik_r       <= aik_s;
      dik_r       <= dik_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

endmodule
